booth_divider_seq: RTL and testbench

- Sequential signed 32-bit divider; the inverse of the ALU's combinational Booth multiplier.
- Writes the quotient to resLo and the remainder to resHi, matching the HI/LO convention of the multiply path (DIV destination registers).
- Radix-2 non-restoring, one quotient bit per clock, with a start/busy/done handshake to the control unit.

---
 rtl/booth_divider_seq_pkg.sv | 19 +
 rtl/booth_divider_seq_if.sv | 25 ++
 rtl/booth_divider_seq_nr_step.sv | 30 +++
 rtl/booth_divider_seq.sv | 140 ++++++++++++++
 tb/tb_booth_divider_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/booth_divider_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } div_state_e;

    // Two's-complement magnitude; |-2^(W-1)| comes out exact as an unsigned value.
    function automatic logic [DIV_WIDTH-1:0] abs_mag(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction
endpackage

// File: rtl/booth_divider_seq_if.sv
// Control-unit to divider handshake: operands and start in, status and HI/LO results out.
interface booth_divider_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] resLo;
    logic [WIDTH-1:0] resHi;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, resLo, resHi
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, resLo, resHi
    );
endinterface

// File: rtl/booth_divider_seq_nr_step.sv
// One radix-2 non-restoring step on the partial remainder A and quotient Q.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, used only while iterating.
module div_nr_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;

    // A stays inside [-M, M), so the final sum fits WIDTH+1 bits even though
    // the shifted intermediate may wrap.
    always_comb begin
        a_sh  = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        m_ext = {1'b0, m_in};
        if (a_in[WIDTH]) begin
            a_out = a_sh + m_ext;
        end else begin
            a_out = a_sh - m_ext;
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end
endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: quotient to resLo, remainder to resHi, one bit per clock.
// Latency: done 33 edges after the start edge (2 for a zero divisor with DIV_ZERO_FAST_EN).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module booth_divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clock,
    input  logic               clear,
    booth_divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] rem_mag;

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_q),
        .q_in  (q_q),
        .m_in  (m_q),
        .a_out (step_a),
        .q_out (step_q)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        dvd_d      = dvd_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        rem_mag    = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = abs_mag(bus.dividend);
                    m_d     = abs_mag(bus.divisor);
                    dvd_d   = bus.dividend;
                    qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rneg_d  = bus.dividend[WIDTH-1];
                    dz_d    = (bus.divisor == '0);
                    a_d     = '0;
                    count_d = '0;
                    state_d = ITER;
`ifdef DIV_ZERO_FAST_EN
                    // Single pass through ITER on its last count: done lands two edges after start.
                    if (bus.divisor == '0) begin
                        count_d = CW'(WIDTH - 1);
                    end
`endif
                end
            end
            ITER: begin
                a_d     = step_a;
                q_d     = step_q;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    res_lo_d = DIV_ZERO_QUOT;
                    res_hi_d = dvd_q;
                end else begin
                    res_lo_d = qneg_q ? (~q_q + 1'b1) : q_q;
                    res_hi_d = rneg_q ? (~rem_mag + 1'b1) : rem_mag;
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            count_q    <= '0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            dvd_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            dvd_q      <= dvd_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.resLo    = res_lo_q;
    assign bus.resHi    = res_hi_q;
endmodule

// File: tb/tb_booth_divider_seq.sv
// Scoreboard bench for booth_divider_seq: stimulus pushes expected results, a monitor checks each done.
module tb_booth_divider_seq;
    logic clock = 1'b0;
    logic clear;

    booth_divider_seq_if bus ();

    booth_divider_seq dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_Z = 2;
`else
    localparam int LAT_Z = 33;
`endif
    localparam int LAT = 33;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_e0;
    int   last_exp;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!clear && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: lo=%h hi=%h at cycle %0d", bus.resLo, bus.resHi, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", bus.resLo, e.lo);
                chk("remainder", bus.resHi, e.hi);
                chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    // Caller is at a negedge; start is accepted at the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input logic dz, input bit push);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.lo  = lo;
        e.hi  = hi;
        e.dz  = dz;
        e.cyc = cyc + 1 + ((b == 32'd0) ? LAT_Z : LAT);
        last_exp = e.cyc;
        if (push) exp_q.push_back(e);
        @(negedge clock);
        last_e0   = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 200) begin
            @(negedge clock);
            g++;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0},
        '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0},
        '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0},
        '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0},
        '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1},
        '{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1},
        '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0},
        '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0},
        '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0},
        '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0},
        '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0},
        '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0},
        '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'd0,        1'b0}
    };

    initial begin
        clear        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("rst_resLo", bus.resLo, 32'd0);
        chk("rst_resHi", bus.resHi, 32'd0);
        clear = 1'b0;
        @(negedge clock);

        // 100 / 7 with busy window edges
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_cyc(last_exp - 1);
        chk("busy_before_done", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].dz, 1'b1);
            wait_idle();
        end

        // clear at E10 of 1000/3 discards the operation
        issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_cyc(last_e0 + 9);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_busy", {31'd0, bus.busy}, 32'd0);
        chk("clr_done", {31'd0, bus.done}, 32'd0);
        chk("clr_resLo", bus.resLo, 32'd0);
        chk("clr_resHi", bus.resHi, 32'd0);
        chk("clr_div_zero", {31'd0, bus.div_zero}, 32'd0);
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_idle();

        // start while busy is ignored
        issue(32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b1);
        wait_cyc(last_e0 + 4);
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
        @(negedge clock);
        bus.start = 1'b0;
        chk("busy_ignore", {31'd0, bus.busy}, 32'd1);
        wait_idle();

        // back-to-back: second start in the done cycle
        issue(32'd50, 32'hFFFFFFFA, 32'hFFFFFFF8, 32'd2, 1'b0, 1'b1);
        wait_cyc(last_exp);
        issue(32'd13, 32'd4, 32'd3, 32'd1, 1'b0, 1'b1);
        wait_idle();

        // signed sweep against the language's truncating / and %
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b, lo, hi;
            a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 2 == 1) b = ~b + 1'b1;
            if (b == 32'd0) b = 32'd3;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'd12345;
            lo = 32'($signed(a) / $signed(b));
            hi = 32'($signed(a) % $signed(b));
            issue(a, b, lo, hi, 1'b0, 1'b1);
            wait_idle();
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
